// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: scans a 3-column x 4-row keypad and debounces both
// press and release. It emits one single-cycle key event per accepted press,
// carrying the 4-bit key code, to the lock controller downstream.
//
// Optional feature macro: KEY_REPEAT_EN. When it is defined, a key held in HELD
// re-pulses key_valid every REPEAT_CNT cycles. When it is undefined, each press
// produces exactly one event.
//
// Ports:
//   clock      system clock (50 MHz nominal)
//   reset      asynchronous, active-high reset
//   row[3:0]   keypad rows, active low (4'b1111 = no key)
//   col[2:0]   column drive, one-hot active low
//   key_valid  one-cycle pulse marking an accepted key
//   key_code   code of the last accepted key, held until the next one
//   key_held   high while an accepted key stays pressed (through release debounce)
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 500,
  parameter int unsigned REPEAT_CNT   = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CNT > SCAN_DIV) ? DEBOUNCE_CNT : SCAN_DIV;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(REPEAT_CNT + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CNT - 1);

`ifdef KEY_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    rs_meta, rs;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] gap_cnt, gap_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [3:0]    lrow, lrow_nxt;
  logic [2:0]    lcol, lcol_nxt;
  logic [2:0]    col_nxt;
  logic          valid_nxt;
  logic [3:0]    code_nxt;
  logic          held_nxt;
  logic [3:0]    map_code_c;

  // Next active-low column: 110 -> 101 -> 011 -> 110.
  function automatic logic [2:0] next_col(input logic [2:0] c);
    return {c[1:0], c[2]};
  endfunction

  // Key code for the latched single-key row and column.
  always_comb begin
    logic [1:0] r_idx;
    logic [1:0] c_idx;
    r_idx = 2'd3;
    c_idx = 2'd2;
    map_code_c = 4'd0;
    case (lrow)
      4'b1110: r_idx = 2'd0;
      4'b1101: r_idx = 2'd1;
      4'b1011: r_idx = 2'd2;
      default: r_idx = 2'd3;
    endcase
    case (lcol)
      3'b110:  c_idx = 2'd0;
      3'b101:  c_idx = 2'd1;
      default: c_idx = 2'd2;
    endcase
    if (r_idx == 2'd3) begin
      case (c_idx)
        2'd0:    map_code_c = 4'd10;
        2'd1:    map_code_c = 4'd0;
        default: map_code_c = 4'd11;
      endcase
    end else begin
      map_code_c = (4'({2'b00, r_idx}) * 4'd3) + 4'({2'b00, c_idx}) + 4'd1;
    end
  end

  // Two-flop row synchroniser; idles at "no key".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      rs_meta <= row;
      rs      <= rs_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      gap_cnt   <= '0;
      rep_cnt   <= '0;
      lrow      <= 4'b1111;
      lcol      <= 3'b110;
      col       <= 3'b110;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      rep_cnt   <= rep_nxt;
      lrow      <= lrow_nxt;
      lcol      <= lcol_nxt;
      col       <= col_nxt;
      key_valid <= valid_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
    end
  end

  // Scan / debounce sequencing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap_cnt;
    rep_nxt   = '0;
    lrow_nxt  = lrow;
    lcol_nxt  = lcol;
    col_nxt   = col;
    valid_nxt = 1'b0;
    code_nxt  = key_code;
    held_nxt  = key_held;

    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (rs != 4'b1111) begin
            lrow_nxt  = rs;
            lcol_nxt  = col;
            gap_nxt   = '0;
            state_nxt = PRESS_DB;
          end else begin
            col_nxt = next_col(col);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      PRESS_DB: begin
        if (rs == lrow) begin
          gap_nxt = '0;
          if (cnt == DB_LAST) begin
            cnt_nxt   = '0;
            state_nxt = HELD;
            // Multi-key chords are swallowed: HELD without an event.
            if ($onehot(~lrow)) begin
              code_nxt  = map_code_c;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
            end else begin
              held_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          cnt_nxt = '0;
          // A press that never settles gives up after a stable idle period.
          if (rs == 4'b1111) begin
            if (gap_cnt == DB_LAST) begin
              gap_nxt   = '0;
              state_nxt = SCAN;
            end else begin
              gap_nxt = gap_cnt + CW'(1);
            end
          end else begin
            gap_nxt = '0;
          end
        end
      end

      HELD: begin
        if (rs == 4'b1111) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end else if (REPEAT_ON && key_held) begin
          if (rep_cnt == REP_LAST) begin
            valid_nxt = 1'b1;
          end else begin
            rep_nxt = rep_cnt + RW'(1);
          end
        end
      end

      REL_DB: begin
        if (rs == 4'b1111) begin
          if (cnt == DB_LAST) begin
            cnt_nxt   = '0;
            held_nxt  = 1'b0;
            col_nxt   = next_col(col);
            state_nxt = SCAN;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end

      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model drives the rows (either gated
// by the active column like a real matrix, or forced raw), expected key codes
// are queued as presses are issued, and a monitor checks every key_valid pulse.
module tb_keypad_scan_debounce;

  logic       clock;
  logic       reset;
  logic [3:0] row;
  logic [2:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  keypad_scan_debounce #(
    .SCAN_DIV    (16),
    .DEBOUNCE_CNT(500),
    .REPEAT_CNT  (1000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

`ifdef KEY_REPEAT_EN
  localparam int REP_EVENTS = 5;
`else
  localparam int REP_EVENTS = 1;
`endif

  int total = 0;
  int bad   = 0;
  int events = 0;
  int cyc = 0;
  int last_evt_cyc = 0;

  logic [3:0] exp_q[$];
  logic [3:0] keymap[4][3];

  // Keypad model: raw row override, or a single key seen only on its column.
  logic       raw_mode;
  logic [3:0] raw_row;
  logic       pressed;
  logic [1:0] pr, pc;

  always_comb begin
    if (raw_mode) row = raw_row;
    else if (pressed && (col[pc] == 1'b0)) row = ~(4'b0001 << pr);
    else row = 4'b1111;
  end

  initial clock = 1'b0;
  always #10 clock = ~clock;
  always @(posedge clock) cyc++;

  // Monitor: every pulse must match the oldest queued expectation.
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        logic [3:0] e;
        events++;
        last_evt_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: key_code=%0d while none expected", key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e) begin
            bad++;
            $display("FAIL event_code: got %0d expected %0d", key_code, e);
          end
        end
        total++;
        if (key_held !== 1'b1) begin
          bad++;
          $display("FAIL held_at_event: got %0d expected 1", key_held);
        end
        total++;
        if (prev_valid) begin
          bad++;
          $display("FAIL back_to_back_valid: got 1 expected 0");
        end
      end
      prev_valid = key_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_events(input int target, input int budget, input string name);
    int n = 0;
    while (events < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(events >= target), 32'd1);
  endtask

  // Aligns stimulus to the start of a column's dwell.
  task automatic wait_col_onset(input logic [2:0] pat);
    int n = 0;
    while (col == pat && n < 100) begin @(negedge clock); n++; end
    while (col != pat && n < 200) begin @(negedge clock); n++; end
    check("col_onset", 32'(col), 32'(pat));
  endtask

  task automatic check_scanning(input string name);
    logic [2:0] c0;
    c0 = col;
    cycles(17);
    check(name, 32'(col != c0), 32'd1);
  endtask

  task automatic bounce_key(input int toggles, input int max_len);
    for (int i = 0; i < toggles; i++) begin
      pressed = ~pressed;
      #($urandom_range(0, max_len));
    end
  endtask

  // Gated press of key (r,c) with bounce, 21 us hold, bouncy release.
  task automatic gated_press(input logic [1:0] r, input logic [1:0] c, input int toggles,
                             input bit timing, input string name);
    int e0, k, d;
    e0 = events;
    raw_mode = 1'b0;
    pr = r;
    pc = c;
    pressed = 1'b0;
    bounce_key(toggles, 1022);
    @(negedge clock);
    pressed = 1'b0;
    cycles(3);
    pressed = 1'b1;
    k = cyc;
    exp_q.push_back(keymap[r][c]);
    wait_events(e0 + 1, 700, {name, "_event"});
    if (timing) begin
      d = last_evt_cyc - k;
      check({name, "_latency_ok"}, 32'(d >= 500 && d <= 550), 32'd1);
    end
    check({name, "_held"}, 32'(key_held), 32'd1);
    while (cyc - k < 1050) @(negedge clock);
    bounce_key(toggles, 1022);
    @(negedge clock);
    pressed = 1'b1;
    cycles(3);
    pressed = 1'b0;
    if (timing) begin
      cycles(490);
      check({name, "_held_before_release"}, 32'(key_held), 32'd1);
      cycles(20);
    end else begin
      cycles(600);
    end
    check({name, "_released"}, 32'(key_held), 32'd0);
    check({name, "_one_event"}, 32'(events - e0), 32'd1);
  endtask

  initial begin
    int e0;
    keymap = '{'{4'd1, 4'd2, 4'd3}, '{4'd4, 4'd5, 4'd6},
               '{4'd7, 4'd8, 4'd9}, '{4'd10, 4'd0, 4'd11}};
    raw_mode = 1'b1;
    raw_row  = 4'b1111;
    pressed  = 1'b0;
    pr = 2'd0;
    pc = 2'd0;
    reset = 1'b1;

    // Reset state and scan rotation.
    #200;
    check("rst_col", 32'(col), 32'(3'b110));
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cycles(15);
    check("scan_c0_dwell", 32'(col), 32'(3'b110));
    cycles(1);
    check("scan_c1", 32'(col), 32'(3'b101));
    cycles(16);
    check("scan_c2", 32'(col), 32'(3'b011));
    cycles(16);
    check("scan_wrap", 32'(col), 32'(3'b110));

    // Key 5 with 30-toggle bounce on both edges.
    gated_press(2'd1, 2'd1, 30, 1'b1, "press5");
    check("press5_code_kept", 32'(key_code), 32'd5);
    check_scanning("press5_scan_resumed");

    // Four raw presses on row 1 that start at column 0.
    raw_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e0 = events;
      wait_col_onset(3'b110);
      raw_row = 4'b1101;
      exp_q.push_back(keymap[1][0]);
      wait_events(e0 + 1, 700, "raw4_event");
      cycles(50);
      raw_row = 4'b1111;
      cycles(600);
      check("raw4_released", 32'(key_held), 32'd0);
      check("raw4_one_event", 32'(events - e0), 32'd1);
    end

    // Random keys through the matrix model.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] r, c;
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 2));
      gated_press(r, c, 10, 1'b0, "rand_key");
    end

    // Bounce only: short random bursts, then idle.
    raw_mode = 1'b1;
    e0 = events;
    for (int i = 0; i < 20; i++) begin
      raw_row = 4'($urandom);
      #($urandom_range(0, 300));
    end
    raw_row = 4'b1111;
    cycles(600);
    check("bounce_no_event", 32'(events - e0), 32'd0);
    check("bounce_not_held", 32'(key_held), 32'd0);
    check_scanning("bounce_scan_resumed");

    // Two keys at once on one column: swallowed.
    e0 = events;
    raw_row = 4'b1001;
    cycles(1050);
    check("multi_not_held", 32'(key_held), 32'd0);
    check("multi_no_event", 32'(events - e0), 32'd0);
    raw_row = 4'b1111;
    cycles(600);
    check_scanning("multi_scan_resumed");

    // '#' held for 5000 cycles.
    e0 = events;
    raw_mode = 1'b0;
    pr = 2'd3;
    pc = 2'd2;
    @(negedge clock);
    pressed = 1'b1;
    for (int i = 0; i < REP_EVENTS; i++) exp_q.push_back(keymap[3][2]);
    cycles(5000);
    pressed = 1'b0;
    cycles(600);
    check("hash_events", 32'(events - e0), 32'(REP_EVENTS));
    check("hash_code", 32'(key_code), 32'd11);
    check("hash_released", 32'(key_held), 32'd0);

    // Reset in the middle of press debounce.
    raw_mode = 1'b1;
    e0 = events;
    wait_col_onset(3'b101);
    raw_row = 4'b1110;
    cycles(220);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_col", 32'(col), 32'(3'b110));
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_code", 32'(key_code), 32'd0);
    check("midrst_held", 32'(key_held), 32'd0);
    raw_row = 4'b1111;
    #200;
    @(negedge clock);
    reset = 1'b0;
    cycles(700);
    check("midrst_no_event", 32'(events - e0), 32'd0);
    check_scanning("midrst_scan_resumed");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
